// File: rtl/serial_receiver_pkg.sv
// Shared UART framing constants and FSM state types for the serial receiver/transmitter pair.
package serial_receiver_pkg;

   localparam int unsigned SYNC_BYTE     = 'h0A;
   localparam int unsigned TICKS_PER_BIT = 8;
   localparam int unsigned TICK_W        = $clog2(TICKS_PER_BIT);
   localparam int unsigned PRESCALE_W    = 16;

   typedef enum logic [1:0] {
      CH_IDLE,
      CH_START,
      CH_DATA,
      CH_STOP
   } char_state_t;

   typedef enum logic [1:0] {
      FR_SYNC,
      FR_HIGH,
      FR_LOW
   } frame_state_t;

endpackage

// File: rtl/uart_rx.sv
// Character-level UART receiver: synchronizer, 1/8-bit tick generator and start/data/stop FSM.
module uart_rx
   import serial_receiver_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rxd,
   input  logic [PRESCALE_W-1:0] prescale,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   output logic                  busy,
   output logic                  frame_error
);

   localparam int unsigned BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   localparam logic [TICK_W-1:0] TICK_HALF = TICK_W'(TICKS_PER_BIT / 2 - 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_BIT - 1);

   logic                  rx_meta, rx_s, rx_d;
   char_state_t           state_q, state_d;
   logic [PRESCALE_W-1:0] presc_q, presc_d;
   logic [TICK_W-1:0]     tick_q, tick_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [DATA_WIDTH-1:0] shift_q, shift_d;
   logic                  busy_q;
   logic                  tick;

   assign tick         = (presc_q == prescale - PRESCALE_W'(1));
   assign m_axis_tdata = shift_q;
   assign busy         = busy_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_d    <= 1'b1;
         state_q <= CH_IDLE;
         presc_q <= '0;
         tick_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         rx_meta <= rxd;
         rx_s    <= rx_meta;
         rx_d    <= rx_s;
         state_q <= state_d;
         presc_q <= presc_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         busy_q  <= (state_d != CH_IDLE);
      end
   end

   // Strobes are combinational so the framer can register them with one cycle of latency.
   always_comb begin
      state_d       = state_q;
      presc_d       = tick ? '0 : presc_q + PRESCALE_W'(1);
      tick_d        = tick_q;
      bit_d         = bit_q;
      shift_d       = shift_q;
      m_axis_tvalid = 1'b0;
      frame_error   = 1'b0;
      case (state_q)
         CH_IDLE: begin
            if (rx_d && !rx_s) begin
               state_d = CH_START;
               presc_d = '0;
               tick_d  = '0;
            end
         end
         CH_START: begin
            if (tick) begin
               tick_d = tick_q + TICK_W'(1);
               if (tick_q == TICK_HALF) begin
                  if (!rx_s) begin
                     state_d = CH_DATA;
                     tick_d  = '0;
                     bit_d   = '0;
                  end else begin
                     state_d = CH_IDLE;
                  end
               end
            end
         end
         CH_DATA: begin
            if (tick) begin
               tick_d = tick_q + TICK_W'(1);
               if (tick_q == TICK_LAST) begin
                  shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
                  bit_d   = bit_q + BIT_W'(1);
                  if (bit_q == BIT_W'(DATA_WIDTH - 1)) state_d = CH_STOP;
               end
            end
         end
         CH_STOP: begin
            if (tick) begin
               tick_d = tick_q + TICK_W'(1);
               if (tick_q == TICK_LAST) begin
                  state_d = CH_IDLE;
                  if (rx_s) m_axis_tvalid = 1'b1;
                  else      frame_error   = 1'b1;
               end
            end
         end
         default: state_d = CH_IDLE;
      endcase
   end

endmodule

// File: rtl/serial_receiver.sv
// UART word receiver: assembles {high, low} words from 0x0A-prefixed three-character frames.
module serial_receiver
   import serial_receiver_pkg::*;
#(
   parameter int unsigned SERIAL_DATA_SIZE = 8,
   parameter int unsigned UART_PRESCALE    = 1302
) (
   input  logic                          i_clock,
   input  logic                          i_reset,
   input  logic                          i_rx,
   output logic [2*SERIAL_DATA_SIZE-1:0] o_data,
   output logic                          o_valid,
   output logic                          o_frame_error,
   output logic                          o_busy
);

   localparam logic [SERIAL_DATA_SIZE-1:0] SYNC_CHAR = SERIAL_DATA_SIZE'(SYNC_BYTE);

   logic [SERIAL_DATA_SIZE-1:0]   char_data;
   logic                          char_valid, char_error;
   frame_state_t                  frame_q, frame_d;
   logic [SERIAL_DATA_SIZE-1:0]   high_q, high_d;
   logic [2*SERIAL_DATA_SIZE-1:0] data_d;
   logic                          valid_d, error_d;

   uart_rx #(.DATA_WIDTH(SERIAL_DATA_SIZE)) u_uart_rx (
      .clk          (i_clock),
      .rst          (i_reset),
      .rxd          (i_rx),
      .prescale     (PRESCALE_W'(UART_PRESCALE)),
      .m_axis_tdata (char_data),
      .m_axis_tvalid(char_valid),
      .busy         (o_busy),
      .frame_error  (char_error)
   );

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         frame_q       <= FR_SYNC;
         high_q        <= '0;
         o_data        <= '0;
         o_valid       <= 1'b0;
         o_frame_error <= 1'b0;
      end else begin
         frame_q       <= frame_d;
         high_q        <= high_d;
         o_data        <= data_d;
         o_valid       <= valid_d;
         o_frame_error <= error_d;
      end
   end

   // Frame FSM; a character error anywhere in a frame drops the partial word.
   always_comb begin
      frame_d = frame_q;
      high_d  = high_q;
      data_d  = o_data;
      valid_d = 1'b0;
      error_d = char_error;
      case (frame_q)
         FR_SYNC: begin
            if (char_valid && (char_data == SYNC_CHAR)) frame_d = FR_HIGH;
         end
         FR_HIGH: begin
            if (char_error) begin
               frame_d = FR_SYNC;
            end else if (char_valid) begin
               high_d  = char_data;
               frame_d = FR_LOW;
            end
         end
         FR_LOW: begin
            if (char_error) begin
               frame_d = FR_SYNC;
            end else if (char_valid) begin
               data_d  = {high_q, char_data};
               valid_d = 1'b1;
               frame_d = FR_SYNC;
            end
         end
         default: frame_d = FR_SYNC;
      endcase
   end

endmodule

// File: tb/tb_serial_receiver.sv
// Directed bench for serial_receiver with a fast prescale (4 clocks per tick, 32 clocks per bit).
module tb_serial_receiver;

   localparam int BIT_CYC = 32;

   logic        i_clock = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_rx    = 1'b1;
   logic [15:0] o_data;
   logic        o_valid, o_frame_error, o_busy;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          valid_cnt, err_cnt, busy_cnt, valid_cyc, last_start_cyc;
   logic [15:0] words[$];

   serial_receiver #(.SERIAL_DATA_SIZE(8), .UART_PRESCALE(4)) dut (
      .i_clock      (i_clock),
      .i_reset      (i_reset),
      .i_rx         (i_rx),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .o_frame_error(o_frame_error),
      .o_busy       (o_busy)
   );

   always #5 i_clock = ~i_clock;
   always @(posedge i_clock) cyc <= cyc + 1;

   always @(negedge i_clock) begin
      if (o_valid) begin
         words.push_back(o_data);
         valid_cnt++;
         valid_cyc = cyc;
      end
      if (o_frame_error) err_cnt++;
      if (o_busy) busy_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      words.delete();
      valid_cnt = 0;
      err_cnt   = 0;
      busy_cnt  = 0;
   endtask

   task automatic drive_bit(input logic v);
      i_rx = v;
      repeat (BIT_CYC) @(negedge i_clock);
   endtask

   task automatic idle(input int n);
      i_rx = 1'b1;
      repeat (n) @(negedge i_clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      last_start_cyc = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
   endtask

   task automatic send_frame(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(8'h0A, 1'b1);
      send_byte(hi, 1'b1);
      send_byte(lo, 1'b1);
   endtask

   function automatic logic [15:0] word_at(input int idx);
      return (idx < words.size()) ? words[idx] : 16'hDEAD;
   endfunction

   initial begin
      clear_mon();
      repeat (3) @(negedge i_clock);
      chk("reset_data",  32'(o_data),        32'h0);
      chk("reset_valid", 32'(o_valid),       32'h0);
      chk("reset_err",   32'(o_frame_error), 32'h0);
      chk("reset_busy",  32'(o_busy),        32'h0);
      i_reset = 1'b1;
      idle(20);

      // Basic frame and stop-sample-to-valid latency
      clear_mon();
      send_frame(8'h12, 8'h34);
      idle(10);
      chk("t1_count",   32'(valid_cnt), 32'd1);
      chk("t1_word",    32'(word_at(0)), 32'h1234);
      chk("t1_err",     32'(err_cnt), 32'd0);
      chk("t1_latency", 32'(valid_cyc - last_start_cyc), 32'd307);

      // Junk before sync, sync byte accepted as high byte
      clear_mon();
      send_byte(8'h55, 1'b1);
      send_byte(8'h0A, 1'b1);
      send_byte(8'h0A, 1'b1);
      send_byte(8'hFF, 1'b1);
      idle(10);
      chk("t2_count", 32'(valid_cnt), 32'd1);
      chk("t2_word",  32'(word_at(0)), 32'h0AFF);
      chk("t2_err",   32'(err_cnt), 32'd0);

      // Stop-bit error drops the partial frame, then recovery
      clear_mon();
      send_byte(8'h0A, 1'b1);
      send_byte(8'hAB, 1'b0);
      idle(40);
      chk("t3_err",      32'(err_cnt), 32'd1);
      chk("t3_no_valid", 32'(valid_cnt), 32'd0);
      chk("t3_data_hold", 32'(o_data), 32'h0AFF);
      send_frame(8'h01, 8'h02);
      idle(10);
      chk("t3_count", 32'(valid_cnt), 32'd1);
      chk("t3_word",  32'(word_at(0)), 32'h0102);

      // Start-bit glitch of two ticks is rejected
      clear_mon();
      i_rx = 1'b0;
      repeat (8) @(negedge i_clock);
      idle(60);
      chk("t4_busy_cycles", 32'(busy_cnt), 32'd16);
      chk("t4_busy_now",    32'(o_busy), 32'h0);
      chk("t4_valid",       32'(valid_cnt), 32'd0);
      chk("t4_err",         32'(err_cnt), 32'd0);

      // Back-to-back frames with no idle gap
      clear_mon();
      send_frame(8'h00, 8'h01);
      send_frame(8'hBE, 8'hEF);
      send_frame(8'hFF, 8'hFF);
      idle(10);
      chk("t5_count", 32'(valid_cnt), 32'd3);
      chk("t5_word0", 32'(word_at(0)), 32'h0001);
      chk("t5_word1", 32'(word_at(1)), 32'hBEEF);
      chk("t5_word2", 32'(word_at(2)), 32'hFFFF);
      chk("t5_err",   32'(err_cnt), 32'd0);

      // Reset in the middle of the high byte
      clear_mon();
      send_byte(8'h0A, 1'b1);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      i_reset = 1'b0;
      i_rx    = 1'b1;
      repeat (3) @(negedge i_clock);
      chk("t6_rst_data",  32'(o_data),        32'h0);
      chk("t6_rst_valid", 32'(o_valid),       32'h0);
      chk("t6_rst_err",   32'(o_frame_error), 32'h0);
      chk("t6_rst_busy",  32'(o_busy),        32'h0);
      i_reset = 1'b1;
      idle(40);
      send_byte(8'h33, 1'b1);
      send_frame(8'h56, 8'h78);
      idle(10);
      chk("t6_count", 32'(valid_cnt), 32'd1);
      chk("t6_word",  32'(word_at(0)), 32'h5678);
      chk("t6_err",   32'(err_cnt), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_receiver.md
SERIAL_RECEIVER -- requirements
Module: serial_receiver

Interface
REQ-001 SHALL have parameter SERIAL_DATA_SIZE, default 8, the UART character width in bits.
REQ-002 SHALL have parameter UART_PRESCALE, default 1302, the clock cycles per 1/8 bit period (9600 baud at 100 MHz).
REQ-003 SHALL have port i_clock  in  1  the single system clock; all logic on its rising edge.
REQ-004 SHALL have port i_reset  in  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 SHALL have port i_rx  in  1  UART serial line, idle high, asynchronous to i_clock.
REQ-006 SHALL have port o_data  out  2*SERIAL_DATA_SIZE  last received word {high byte, low byte}.
REQ-007 SHALL have port o_valid  out  1  one-cycle pulse when o_data is updated.
REQ-008 SHALL have port o_frame_error  out  1  one-cycle pulse on stop-bit error or frame abort.
REQ-009 SHALL have port o_busy  out  1  high while a character is being received.

Function
REQ-010 SHALL pass i_rx through a 2-flop synchronizer (reset value 1) before any use.
REQ-011 SHALL generate a sample tick once every UART_PRESCALE cycles from a free-running counter that reloads on tick; 8 ticks = 1 bit.
REQ-012 Character FSM SHALL have states IDLE, START, DATA, STOP; o_busy = (state != IDLE).
REQ-013 IDLE -> START on a synchronized falling edge (1 then 0); tick phase SHALL be realigned to that edge.
REQ-014 START: after 4 ticks, line 0 -> DATA; line 1 -> IDLE (glitch rejected, no error).
REQ-015 DATA: SHALL sample every 8 ticks, SERIAL_DATA_SIZE bits LSB first, then -> STOP.
REQ-016 STOP: after 8 ticks, line 1 -> character accepted (1-cycle internal strobe), -> IDLE; line 0 -> o_frame_error pulse, character discarded, wait in IDLE until line returns high.
REQ-017 Frame FSM SHALL have states SYNC, HIGH, LOW; frame = 0x0A, high byte, low byte.
REQ-018 SYNC: accepted char 0x0A -> HIGH; any other char is discarded, state stays SYNC, no error.
REQ-019 HIGH: any accepted char (including 0x0A) SHALL be latched as high byte -> LOW.
REQ-020 LOW: accepted char -> o_data <= {high, char}, o_valid pulses the next cycle, -> SYNC.
REQ-021 Stop-bit error while in HIGH or LOW SHALL return frame FSM to SYNC; partial word is dropped; o_data unchanged.
REQ-022 Latency: o_valid SHALL assert exactly 1 cycle after the low-byte stop-bit sample cycle.
REQ-023 o_data SHALL hold its value between o_valid pulses; no backpressure, no buffering beyond one word.
REQ-024 Back-to-back frames with zero idle time between stop and next start bit SHALL be received without loss.

Reset
REQ-025 While i_reset = 0: o_data = 0, o_valid = 0, o_frame_error = 0, o_busy = 0, both FSMs in IDLE/SYNC, counters 0, synchronizer flops 1.
REQ-026 Reset asserted mid-character or mid-frame SHALL discard all partial data; after release the first accepted word requires a fresh 0x0A.

Structure
REQ-027 A shared package SHALL hold the sync byte constant (0x0A), the ticks-per-bit constant (8), and the character and frame FSM state typedefs, all shared with the serial transmitter.
REQ-028 The character-level receiver SHALL be a sub-module, uart_rx (ports clk, rst, rxd, prescale, m_axis_tdata, m_axis_tvalid, busy, frame_error), mirroring uart_tx; serial_receiver holds the framing FSM.

Verification (UART_PRESCALE overridden to 4 for simulation)
REQ-029 Send 0x0A, 0x12, 0x34 -> one o_valid pulse, o_data = 0x1234, no o_frame_error.
REQ-030 Send 0x55, 0x0A, 0x0A, 0xFF -> 0x55 ignored; o_data = 0x0AFF, one o_valid.
REQ-031 Send 0x0A, 0xAB with stop bit forced 0 -> o_frame_error pulse; then send 0x0A, 0x01, 0x02 -> o_data = 0x0102.
REQ-032 Drive an i_rx low glitch of 2 ticks -> no o_busy persistence beyond START, no outputs.
REQ-033 Send three back-to-back frames 0x0A/0x00/0x01, 0x0A/0xBE/0xEF, 0x0A/0xFF/0xFF -> three o_valid pulses with those words in order.
REQ-034 Assert i_reset during the high byte of a frame -> all outputs 0; next 0x0A, 0x56, 0x78 -> o_data = 0x5678.
